// File: rtl/tmds_decoder.sv
`timescale 1ns/1ps
// ============================================================================
// tmds_decoder
// ----------------------------------------------------------------------------
// Single-channel TMDS receive decoder. Raw 10-bit words from a 1:10
// deserializer arrive unaligned; the decoder hunts for the symbol boundary by
// sliding a 10-bit view across two consecutive words until it sees a run of
// control tokens, then decodes each aligned symbol into a pixel byte, two
// control bits and a data-enable flag. One instance per colour channel.
//
// Parameters:
//   LOCK_COUNT   - consecutive control tokens needed to declare lock
//   HUNT_WINDOW  - cycles spent on one offset before bit-slipping
//                  (must exceed one video line)
//   LOSS_TIMEOUT - cycles without any control token before lock is dropped
//
// Ports:
//   pixclk   in   1  pixel clock, the only clock
//   rst      in   1  asynchronous active-low reset
//   tmds_i   in  10  raw deserialized word, bit 0 received first
//   data_o   out  8  decoded pixel byte
//   ctrl_o   out  2  decoded control bits {c1,c0}
//   de_o     out  1  1 = data symbol, 0 = control symbol
//   locked_o out  1  symbol alignment achieved
//   offset_o out  4  current bit-slip offset, 0..9
// ============================================================================
module tmds_decoder #(
    parameter int LOCK_COUNT   = 32,
    parameter int HUNT_WINDOW  = 1024,
    parameter int LOSS_TIMEOUT = 2048
) (
    input  logic       pixclk,
    input  logic       rst,
    input  logic [9:0] tmds_i,
    output logic [7:0] data_o,
    output logic [1:0] ctrl_o,
    output logic       de_o,
    output logic       locked_o,
    output logic [3:0] offset_o
);

    localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W  = $clog2(HUNT_WINDOW + 1);
    localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

    localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(HUNT_WINDOW - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

    typedef enum logic {
        ST_HUNT,
        ST_LOCKED
    } state_t;

    state_t            state, state_n;
    logic [9:0]        prev;
    logic [3:0]        offset, offset_n;
    logic [HIT_W-1:0]  hit_cnt, hit_n;
    logic [WIN_W-1:0]  win_cnt, win_n;
    logic [LOSS_W-1:0] loss_cnt, loss_n;

    logic [19:0] window;
    logic [19:0] shifted;
    logic [9:0]  sym;
    logic        is_token;
    logic [1:0]  token_val;
    logic [7:0]  q;
    logic [7:0]  dec;
    logic [7:0]  data_n;
    logic [1:0]  ctrl_n;
    logic        de_n;

    // The previous word supplies the low half of the window, so a symbol that
    // straddles two deserializer words can be reassembled at any offset.
    assign window  = {tmds_i, prev};
    assign shifted = window >> offset;
    assign sym     = shifted[9:0];

    always_comb begin
        is_token  = 1'b1;
        token_val = 2'b00;
        case (sym)
            10'h354: token_val = 2'b00;
            10'h0AB: token_val = 2'b01;
            10'h154: token_val = 2'b10;
            10'h2AB: token_val = 2'b11;
            default: is_token  = 1'b0;
        endcase
    end

    // Undo the transmit-side DC balancing (bit 9) and then the XOR/XNOR
    // transition minimisation (bit 8). No disparity checking is done, so
    // invalid symbols simply decode as data.
    always_comb begin
        q      = sym[9] ? ~sym[7:0] : sym[7:0];
        dec    = '0;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    // Alignment FSM. While hunting, a full run of tokens locks; otherwise the
    // window expiry slips the offset by one bit. Lock takes priority over the
    // slip so a run that completes on the last window cycle is not thrown
    // away. Once locked, the offset is frozen until tokens stop arriving for
    // a full loss timeout.
    always_comb begin
        state_n  = state;
        offset_n = offset;
        hit_n    = hit_cnt;
        win_n    = win_cnt;
        loss_n   = loss_cnt;
        case (state)
            ST_HUNT: begin
                hit_n = is_token ? hit_cnt + 1'b1 : '0;
                if (is_token && (hit_cnt == HIT_LAST)) begin
                    state_n = ST_LOCKED;
                    loss_n  = '0;
                    hit_n   = '0;
                    win_n   = '0;
                end else if (win_cnt == WIN_LAST) begin
                    offset_n = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                    hit_n    = '0;
                    win_n    = '0;
                end else begin
                    win_n = win_cnt + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (is_token) begin
                    loss_n = '0;
                end else if (loss_cnt == LOSS_LAST) begin
                    state_n = ST_HUNT;
                    hit_n   = '0;
                    win_n   = '0;
                end else begin
                    loss_n = loss_cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_HUNT;
            end
        endcase
    end

    // Output selection uses the state before the edge, so decoded symbols
    // appear one edge after locked_o rises. During data periods the control
    // bits keep the value of the last token (channel 0 sync levels persist).
    always_comb begin
        data_n = '0;
        ctrl_n = '0;
        de_n   = 1'b0;
        if (state == ST_LOCKED) begin
            if (is_token) begin
                ctrl_n = token_val;
            end else begin
                de_n   = 1'b1;
                data_n = dec;
                ctrl_n = ctrl_o;
            end
        end
    end

    // State, counters, the delayed word and the output register.
    always_ff @(posedge pixclk or negedge rst) begin
        if (!rst) begin
            state    <= ST_HUNT;
            prev     <= '0;
            offset   <= '0;
            hit_cnt  <= '0;
            win_cnt  <= '0;
            loss_cnt <= '0;
            data_o   <= '0;
            ctrl_o   <= '0;
            de_o     <= 1'b0;
        end else begin
            state    <= state_n;
            prev     <= tmds_i;
            offset   <= offset_n;
            hit_cnt  <= hit_n;
            win_cnt  <= win_n;
            loss_cnt <= loss_n;
            data_o   <= data_n;
            ctrl_o   <= ctrl_n;
            de_o     <= de_n;
        end
    end

    assign locked_o = (state == ST_LOCKED);
    assign offset_o = offset;

endmodule

// File: tb/tb_tmds_decoder.sv
`timescale 1ns/1ps
// ============================================================================
// tb_tmds_decoder
// ----------------------------------------------------------------------------
// Self-checking bench for tmds_decoder. Every clock edge is mirrored by a
// behavioural reference that works on the serial symbol stream with plain
// integers; all outputs are compared each cycle, plus targeted checks of the
// lock, decode, bit-slip, loss, lock-versus-slip and async reset behaviour.
// ============================================================================
module tb_tmds_decoder;

    localparam int LOCK_COUNT   = 32;
    localparam int HUNT_WINDOW  = 1024;
    localparam int LOSS_TIMEOUT = 2048;

    logic       pixclk;
    logic       rst;
    logic [9:0] tmds_i;
    logic [7:0] data_o;
    logic [1:0] ctrl_o;
    logic       de_o;
    logic       locked_o;
    logic [3:0] offset_o;

    int vec_count;
    int err_count;

    // Reference state
    logic [9:0] m_prev;
    logic       m_locked;
    int         m_offset;
    int         m_hits;
    int         m_win;
    int         m_idle;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;
    logic       m_de;

    logic [9:0]  tokens [4];
    logic [15:0] dut_bus;

    tmds_decoder #(
        .LOCK_COUNT  (LOCK_COUNT),
        .HUNT_WINDOW (HUNT_WINDOW),
        .LOSS_TIMEOUT(LOSS_TIMEOUT)
    ) dut (
        .pixclk  (pixclk),
        .rst     (rst),
        .tmds_i  (tmds_i),
        .data_o  (data_o),
        .ctrl_o  (ctrl_o),
        .de_o    (de_o),
        .locked_o(locked_o),
        .offset_o(offset_o)
    );

    assign dut_bus = {locked_o, offset_o, de_o, ctrl_o, data_o};

    // Free-running pixel clock, 10 ns period
    initial begin
        pixclk = 1'b0;
        forever #5 pixclk = ~pixclk;
    end

    // Hard stop in case something never returns
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int token_of(input logic [9:0] s);
        case (s)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] decode_byte(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q    = s[9] ? ~s[7:0] : s[7:0];
        d    = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    // Raw word whose bits k..9 start the current symbol and whose bits 0..k-1
    // finish the previous one, i.e. the symbol boundary sits k bits in.
    function automatic logic [9:0] make_word(input int k, input logic [9:0] cur,
                                             input logic [9:0] prv);
        logic [19:0] pair;
        pair = {cur, prv};
        pair = pair >> (10 - k);
        return pair[9:0];
    endfunction

    function automatic logic [9:0] random_data();
        logic [9:0] x;
        do begin
            x = 10'($urandom);
        end while (token_of(x) >= 0);
        return x;
    endfunction

    function automatic logic [15:0] model_bus();
        return {m_locked, 4'(m_offset), m_de, m_ctrl, m_data};
    endfunction

    task automatic model_reset();
        m_prev   = '0;
        m_locked = 1'b0;
        m_offset = 0;
        m_hits   = 0;
        m_win    = 0;
        m_idle   = 0;
        m_data   = '0;
        m_ctrl   = '0;
        m_de     = 1'b0;
    endtask

    // One pixel-clock edge of the reference, using pre-edge values.
    task automatic model_step(input logic [9:0] w);
        logic [19:0] pair;
        logic [9:0]  sym;
        int          tok;
        pair = {w, m_prev};
        sym  = 10'(pair >> m_offset);
        tok  = token_of(sym);

        if (!m_locked) begin
            m_data = '0;
            m_ctrl = '0;
            m_de   = 1'b0;
        end else if (tok >= 0) begin
            m_data = '0;
            m_ctrl = 2'(tok);
            m_de   = 1'b0;
        end else begin
            m_data = decode_byte(sym);
            m_de   = 1'b1;
        end

        if (!m_locked) begin
            m_hits = (tok >= 0) ? m_hits + 1 : 0;
            if (m_hits == LOCK_COUNT) begin
                m_locked = 1'b1;
                m_idle   = 0;
                m_hits   = 0;
                m_win    = 0;
            end else if (m_win == HUNT_WINDOW - 1) begin
                m_offset = (m_offset + 1) % 10;
                m_hits   = 0;
                m_win    = 0;
            end else begin
                m_win = m_win + 1;
            end
        end else begin
            if (tok >= 0) begin
                m_idle = 0;
            end else if (m_idle == LOSS_TIMEOUT - 1) begin
                m_locked = 1'b0;
                m_hits   = 0;
                m_win    = 0;
            end else begin
                m_idle = m_idle + 1;
            end
        end
        m_prev = w;
    endtask

    // Present a word, clock it in, advance the reference and compare.
    task automatic apply_stimulus(input logic [9:0] w);
        tmds_i = w;
        @(posedge pixclk);
        if (rst) model_step(w);
        else     model_reset();
        #1;
        check_output("cycle", 32'(dut_bus), 32'(model_bus()));
    endtask

    task automatic enter_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check_output("reset_bus", 32'(dut_bus), 32'h0);
        repeat (3) apply_stimulus(10'($urandom));
        @(negedge pixclk);
        rst = 1'b1;
    endtask

    initial begin
        logic [9:0] s_cur;
        logic [9:0] s_prv;
        int         t;

        tokens[0] = 10'h354;
        tokens[1] = 10'h0AB;
        tokens[2] = 10'h154;
        tokens[3] = 10'h2AB;
        vec_count = 0;
        err_count = 0;
        rst       = 1'b0;
        tmds_i    = '0;
        model_reset();

        // Reset held with random input, then lock on plain tokens at offset 0
        repeat (5) apply_stimulus(10'($urandom));
        check_output("reset_outputs", 32'(dut_bus), 32'h0);
        @(negedge pixclk);
        rst = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            apply_stimulus(10'h354);
            if (i == 32) check_output("lock_not_yet", 32'(locked_o), 32'h0);
            if (i == 33) check_output("lock_rise", 32'(locked_o), 32'h1);
        end
        check_output("lock_offset", 32'(offset_o), 32'h0);
        check_output("lock_ctrl_de", 32'({ctrl_o, de_o}), 32'h0);

        // Directed decode sequence
        apply_stimulus(10'h0AB);
        apply_stimulus(10'h100);
        check_output("dec_ctrl01", 32'({ctrl_o, de_o}), 32'h2);
        apply_stimulus(10'h1FF);
        check_output("dec_100", 32'({ctrl_o, de_o, data_o}), 32'h300);
        apply_stimulus(10'h3FF);
        check_output("dec_1ff", 32'({de_o, data_o}), 32'h101);
        apply_stimulus(10'h354);
        check_output("dec_3ff", 32'({de_o, data_o}), 32'h100);
        apply_stimulus(10'h354);
        check_output("dec_tok00", 32'({ctrl_o, de_o}), 32'h0);

        // Random mix of data and tokens while locked
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) apply_stimulus(tokens[$urandom_range(0, 3)]);
            else                           apply_stimulus(10'($urandom));
        end

        // Bit-slip: boundary 3 bits into each word, 160-token blank per 800
        enter_reset();
        s_prv = '0;
        t     = 0;
        while (t < 5000 && !m_locked) begin
            s_cur = ((t % 800) < 160) ? 10'h354 : random_data();
            apply_stimulus(make_word(3, s_cur, s_prv));
            s_prv = s_cur;
            t++;
            if (t == 1023) check_output("slip_off0", 32'(offset_o), 32'h0);
            if (t == 1024) check_output("slip_off1", 32'(offset_o), 32'h1);
            if (t == 2048) check_output("slip_off2", 32'(offset_o), 32'h2);
            if (t == 3072) check_output("slip_off3", 32'(offset_o), 32'h3);
        end
        check_output("slip_locked", 32'(locked_o), 32'h1);
        check_output("slip_offset", 32'(offset_o), 32'h3);

        // Loss of lock at offset 3 after a long run of data symbols
        for (int i = 0; i < 10; i++) begin
            s_cur = 10'h354;
            apply_stimulus(make_word(3, s_cur, s_prv));
            s_prv = s_cur;
        end
        for (int j = 1; j <= 2050; j++) begin
            s_cur = 10'h100;
            apply_stimulus(make_word(3, s_cur, s_prv));
            s_prv = s_cur;
            if (j == 2048) check_output("loss_still", 32'(locked_o), 32'h1);
            if (j == 2049) begin
                check_output("loss_drop", 32'(locked_o), 32'h0);
                check_output("loss_offset", 32'(offset_o), 32'h3);
            end
            if (j == 2050) check_output("loss_de", 32'(de_o), 32'h0);
        end

        // 32nd token lands on the last cycle of the first hunt window
        enter_reset();
        for (int k = 1; k <= 1030; k++) begin
            if (k < 992) apply_stimulus(random_data());
            else         apply_stimulus(10'h354);
            if (k == 1023) check_output("simul_pre", 32'(locked_o), 32'h0);
            if (k == 1024) begin
                check_output("simul_lock", 32'(locked_o), 32'h1);
                check_output("simul_offset", 32'(offset_o), 32'h0);
            end
        end
        check_output("simul_hold", 32'(offset_o), 32'h0);

        // Lock at offset 5, then pull reset between edges
        enter_reset();
        s_prv = '0;
        t     = 0;
        while (t < 6000 && !m_locked) begin
            s_cur = 10'h354;
            apply_stimulus(make_word(5, s_cur, s_prv));
            s_prv = s_cur;
            t++;
        end
        for (int i = 0; i < 4; i++) begin
            s_cur = tokens[$urandom_range(0, 3)];
            apply_stimulus(make_word(5, s_cur, s_prv));
            s_prv = s_cur;
        end
        check_output("off5_locked", 32'({locked_o, offset_o}), 32'h15);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check_output("async_rst_lock", 32'(locked_o), 32'h0);
        check_output("async_rst_offset", 32'(offset_o), 32'h0);
        check_output("async_rst_bus", 32'(dut_bus), 32'h0);
        repeat (2) apply_stimulus(10'($urandom));
        @(negedge pixclk);
        rst = 1'b1;
        repeat (3) apply_stimulus(10'h354);
        check_output("post_rst_offset", 32'({locked_o, offset_o}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
